vga_display: RTL and testbench
==============================

Name: vga_display

Overview:
- Fixed-mode 640x480 VGA scan-out engine; 800 clocks/line, 525 lines/frame, one pixel per clk.
- Pulls RGB565 pixels from an Avalon-ST frame stream, e.g. a frame-reader DMA.
- Generates HSYNC/VSYNC and truncated RGB outputs.
- Once per frame, issues a restart command to the frame reader over an Avalon-MM CSR master port.

Parameters:
- ST_DATA_WIDTH, default 16: pixel word width, RGB565.
- MM_CSR_ADDR_WIDTH, default 4 (vga_pkg constant): CSR address width.
- MM_CSR_DATA_WIDTH, default 32 (vga_pkg constant): CSR data width.
- DISPLAY_CDEPTH, default 4 (vga_pkg constant): bits per colour output.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- st_ready  out  1  sink ready; one beat consumed per cycle with st_ready && st_valid.
- st_data  in  ST_DATA_WIDTH  pixel: [15:11] R, [10:5] G, [4:0] B.
- st_startofpacket  in  1  first beat of frame.
- st_endofpacket  in  1  last beat of frame.
- st_valid  in  1  source data valid.
- mm_csr_write  out  1  CSR write request.
- mm_csr_address  out  MM_CSR_ADDR_WIDTH  CSR address; always 0.
- mm_csr_writedata  out  MM_CSR_DATA_WIDTH  CSR data; 1 = restart.
- mm_csr_waitrequest  in  1  slave stall.
- vga_hs_out  out  1  HSYNC, active low.
- vga_vs_out  out  1  VSYNC, active low.
- vga_r, vga_g, vga_b  out  DISPLAY_CDEPTH each  colour.

Behaviour:
- Reset values: st_ready=0, mm_csr_write=0, mm_csr_address=0, mm_csr_writedata=0, hs=1, vs=1, rgb=0.
- Counters: h 0..799 and v 0..524. h wraps to 0 and increments v; v wraps to 0 after line 524.
- Active region: h<640 && v<480.
- Horizontal timing: front porch h 640..655, sync h 656..751 (hs=0), back porch h 752..799.
- Vertical timing: front porch v 480..489, sync v 490..491 (vs=0), back porch v 492..524.
- Control FSM states: RESTART, RUN, DRAIN.
- RESTART:
  - Drive mm_csr_write=1, address 0, writedata 1; address and data are held stable.
  - The write stays asserted through the first cycle with waitrequest=0 and deasserts the next cycle; exactly one accepted write per restart.
  - Entered immediately after reset, with counters held at (0,0) and outputs blank.
  - Leaving the initial RESTART enters RUN with counters starting at h=0, v=0.
- RUN: st_ready=1 exactly in active-region cycles, giving 307200 ready cycles per frame. The first is the cycle at h=0, v=0.
- DRAIN:
  - Entered at h=0, v=480.
  - st_ready=1 until a beat with st_valid && st_endofpacket is consumed; st_ready drops the cycle after.
  - A frame packet is therefore 307201 beats, with the trailing EOP beat discarded.
  - After EOP, go to RESTART; a restart write is issued once per frame, during vertical blanking.
  - After the restart is accepted, wait in RUN until v wraps to 0.
- Timing counters run freely in all states except the initial RESTART after reset.
- Pixel output: registered. The beat consumed in cycle N drives rgb in cycle N+1 as R=data[15:12], G=data[10:7], B=data[4:1].
- hs/vs are delayed one cycle to align with rgb.
- Outside the active region, or if st_valid=0 in an active cycle (underflow), rgb=0 that cycle. No stall: the timing continues and the missing pixel is dropped.
- st_startofpacket is ignored for alignment.
- Reset mid-frame: everything returns to reset values, and a new initial RESTART is issued.

Test Plan:
- Reset then release, waitrequest=1 → mm_csr_write=1, address 0, writedata 1, held while stalled. Release waitrequest → write still high that cycle, low the next.
- Counting source (data=index, SOP at 0, EOP at 307200, valid=1) → exactly 307201 ready cycles per frame. Counter back at 0 with frames=1 within 525*800-3 cycles after restart acceptance.
- Second frame → another restart write (addr 0, data 1) once per frame. Frames=2 and counter=0 after a further 525*800 cycles.
- Sync check → hs low for 96 clocks every 800 clocks. vs low for 2 lines (1600 clocks) every 420000 clocks.
- Pixel mapping: data 16'hF81F in an active cycle → next cycle R=F, G=0, B=F. All blanking cycles → rgb=0.
- Drive st_valid=0 for 10 active cycles → rgb=0 for those pixels, sync timing unchanged. Assert reset mid-frame → outputs return to reset values and a new restart is issued.

Source files
------------

// File: rtl/vga_display.sv
// Fixed-timing VGA scan-out engine: pulls RGB565 beats from an Avalon-ST frame stream
// and restarts the frame reader once per frame through an Avalon-MM CSR write.

package vga_pkg;
   localparam int unsigned MM_CSR_ADDR_WIDTH = 4;
   localparam int unsigned MM_CSR_DATA_WIDTH = 32;
   localparam int unsigned DISPLAY_CDEPTH    = 4;

   typedef enum logic [1:0] {
      ST_RESTART = 2'd0,
      ST_RUN     = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   typedef struct packed {
      logic [DISPLAY_CDEPTH-1:0] r;
      logic [DISPLAY_CDEPTH-1:0] g;
      logic [DISPLAY_CDEPTH-1:0] b;
   } rgb_t;
endpackage

module vga_display
   import vga_pkg::*;
#(
   parameter int unsigned ST_DATA_WIDTH = 16,
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned H_FRONT       = 16,
   parameter int unsigned H_SYNC        = 96,
   parameter int unsigned H_BACK        = 48,
   parameter int unsigned V_ACTIVE      = 480,
   parameter int unsigned V_FRONT       = 10,
   parameter int unsigned V_SYNC        = 2,
   parameter int unsigned V_BACK        = 33
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         st_ready,
   input  logic [ST_DATA_WIDTH-1:0]     st_data,
   input  logic                         st_startofpacket,
   input  logic                         st_endofpacket,
   input  logic                         st_valid,
   output logic                         mm_csr_write,
   output logic [MM_CSR_ADDR_WIDTH-1:0] mm_csr_address,
   output logic [MM_CSR_DATA_WIDTH-1:0] mm_csr_writedata,
   input  logic                         mm_csr_waitrequest,
   output logic                         vga_hs_out,
   output logic                         vga_vs_out,
   output logic [DISPLAY_CDEPTH-1:0]    vga_r,
   output logic [DISPLAY_CDEPTH-1:0]    vga_g,
   output logic [DISPLAY_CDEPTH-1:0]    vga_b
);

   localparam int unsigned H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HW         = $clog2(H_TOTAL);
   localparam int unsigned VW         = $clog2(V_TOTAL);
   localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FRONT;
   localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
   localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FRONT;
   localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic                         r_init;
   logic                         w_init_nxt;
   logic [HW-1:0]                r_h;
   logic [HW-1:0]                w_h_nxt;
   logic [VW-1:0]                r_v;
   logic [VW-1:0]                w_v_nxt;
   logic                         r_ready;
   logic                         w_ready_nxt;
   logic                         r_write;
   logic                         w_write_nxt;
   logic [MM_CSR_DATA_WIDTH-1:0] r_wdata;
   logic [MM_CSR_DATA_WIDTH-1:0] w_wdata_nxt;
   logic                         r_hs;
   logic                         r_vs;
   rgb_t                         r_rgb;
   rgb_t                         w_rgb_nxt;
   logic                         w_accept;
   logic                         w_beat;
   logic                         w_hsync;
   logic                         w_vsync;
   logic                         w_unused;

   // SOP is not used for alignment; the low colour bits are truncated away.
   assign w_unused = ^{st_startofpacket, st_data};

   assign w_accept = r_write && !mm_csr_waitrequest;
   assign w_beat   = r_ready && st_valid;
   assign w_hsync  = (r_h >= HW'(H_SYNC_BEG)) && (r_h < HW'(H_SYNC_END));
   assign w_vsync  = (r_v >= VW'(V_SYNC_BEG)) && (r_v < VW'(V_SYNC_END));

   // Next-state, counter and registered-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_init_nxt  = r_init;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      w_wdata_nxt = r_wdata;
      w_rgb_nxt   = '0;

      // Counters are frozen only during the restart that follows reset.
      if (!(r_state == ST_RESTART && r_init)) begin
         if (r_h == HW'(H_TOTAL - 1)) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + VW'(1);
         end else begin
            w_h_nxt = r_h + HW'(1);
         end
      end

      case (r_state)
         ST_RESTART: begin
            if (w_accept) begin
               w_state_nxt = ST_RUN;
               w_init_nxt  = 1'b0;
            end
         end
         ST_RUN: begin
            if (w_h_nxt == '0 && w_v_nxt == VW'(V_ACTIVE)) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_beat && st_endofpacket) begin
               w_state_nxt = ST_RESTART;
            end
         end
         default: w_state_nxt = ST_RESTART;
      endcase

      w_ready_nxt = (w_state_nxt == ST_DRAIN) ||
                    (w_state_nxt == ST_RUN && w_h_nxt < HW'(H_ACTIVE) && w_v_nxt < VW'(V_ACTIVE));
      w_write_nxt = (w_state_nxt == ST_RESTART);
      if (w_write_nxt) begin
         w_wdata_nxt = MM_CSR_DATA_WIDTH'(1);
      end

      // Ready in RUN implies the active region; drained beats are never shown.
      if (w_beat && r_state == ST_RUN) begin
         w_rgb_nxt.r = st_data[15 -: DISPLAY_CDEPTH];
         w_rgb_nxt.g = st_data[10 -: DISPLAY_CDEPTH];
         w_rgb_nxt.b = st_data[4 -: DISPLAY_CDEPTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RESTART;
         r_init  <= 1'b1;
         r_h     <= '0;
         r_v     <= '0;
         r_ready <= 1'b0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_rgb   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_init  <= w_init_nxt;
         r_h     <= w_h_nxt;
         r_v     <= w_v_nxt;
         r_ready <= w_ready_nxt;
         r_write <= w_write_nxt;
         r_wdata <= w_wdata_nxt;
         r_hs    <= !w_hsync;
         r_vs    <= !w_vsync;
         r_rgb   <= w_rgb_nxt;
      end
   end

   assign st_ready         = r_ready;
   assign mm_csr_write     = r_write;
   assign mm_csr_address   = '0;
   assign mm_csr_writedata = r_wdata;
   assign vga_hs_out       = r_hs;
   assign vga_vs_out       = r_vs;
   assign vga_r            = r_rgb.r;
   assign vga_g            = r_rgb.g;
   assign vga_b            = r_rgb.b;

endmodule

// File: tb/tb_vga_display.sv
// Randomized bench for vga_display in a reduced timing mode, checked cycle by cycle
// against a frame-position model (position = cycles since restart acceptance).

module tb_vga_display;
   localparam int HA = 40, HF = 4, HS = 8, HB = 6;
   localparam int VA = 30, VF = 3, VS = 2, VB = 5;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int ACT = HA * VA;
   localparam int MAX_CYC = 20000;
   localparam int M_RST = 0, M_INIT = 1, M_TIMED = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_ready;
   logic [15:0] st_data;
   logic        st_startofpacket;
   logic        st_endofpacket;
   logic        st_valid;
   logic        mm_csr_write;
   logic [3:0]  mm_csr_address;
   logic [31:0] mm_csr_writedata;
   logic        mm_csr_waitrequest;
   logic        vga_hs_out;
   logic        vga_vs_out;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;

   vga_display #(
      .ST_DATA_WIDTH(16),
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .st_ready(st_ready),
      .st_data(st_data),
      .st_startofpacket(st_startofpacket),
      .st_endofpacket(st_endofpacket),
      .st_valid(st_valid),
      .mm_csr_write(mm_csr_write),
      .mm_csr_address(mm_csr_address),
      .mm_csr_writedata(mm_csr_writedata),
      .mm_csr_waitrequest(mm_csr_waitrequest),
      .vga_hs_out(vga_hs_out),
      .vga_vs_out(vga_vs_out),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_active(input int pp);
      return ((pp % HT) < HA) && ((pp / HT) < VA);
   endfunction

   function automatic bit in_hsync(input int pp);
      int h = pp % HT;
      return (h >= HA + HF) && (h < HA + HF + HS);
   endfunction

   function automatic bit in_vsync(input int pp);
      int v = pp / HT;
      return (v >= VA + VF) && (v < VA + VF + VS);
   endfunction

   function automatic logic [11:0] pix(input logic [15:0] d);
      return {d[15:12], d[10:7], d[4:1]};
   endfunction

   // model state: expected outputs for the current cycle plus frame position
   int          mode = M_RST;
   int          p = 0;
   int          frame_no = 0;
   int          init_cnt = 0;
   int          n_init_acc = 0;
   int          rst_left = 3;
   bit          have_frame = 0;
   bit          drain = 0;
   bit          done = 0;
   logic        e_ready = 0, e_write = 0, e_hs = 1, e_vs = 1;
   logic [11:0] e_rgb = '0;

   // source and per-frame accumulators
   int src_idx = 0, src_frames = 0;
   int rdy_cnt = 0, hs_lo = 0, vs_lo = 0, wr_acc = 0, drops = 0;

   initial begin
      bit reset_drv;
      bit eop_taken;
      bit accept;
      int pn;
      reset = 1'b1;
      st_data = '0;
      st_startofpacket = 1'b0;
      st_endofpacket = 1'b0;
      st_valid = 1'b0;
      mm_csr_waitrequest = 1'b1;

      for (int c = 0; c < MAX_CYC && !done; c++) begin
         @(negedge clk);
         check("st_ready", 32'(st_ready), 32'(e_ready));
         check("csr_write", 32'(mm_csr_write), 32'(e_write));
         check("csr_address", 32'(mm_csr_address), 32'd0);
         if (mm_csr_write) check("csr_writedata", mm_csr_writedata, 32'd1);
         check("hs", 32'(vga_hs_out), 32'(e_hs));
         check("vs", 32'(vga_vs_out), 32'(e_vs));
         check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));

         if (mode == M_TIMED) begin
            if (p == 0 && have_frame) begin
               check("ready_per_frame", 32'(rdy_cnt), 32'(ACT + 1 + drops));
               check("hs_low_per_frame", 32'(hs_lo), 32'(HS * VT));
               check("vs_low_per_frame", 32'(vs_lo), 32'(VS * HT));
               check("restarts_per_frame", 32'(wr_acc), 32'd1);
               frame_no++;
               rdy_cnt = 0; hs_lo = 0; vs_lo = 0; wr_acc = 0; drops = 0;
            end
            if (p == 0) have_frame = 1;
            if (p == 1 && frame_no == 0) check("pix_f81f", 32'({vga_r, vga_g, vga_b}), 32'h0F0F);
            if (p == FRAME - 3 && n_init_acc == 1) begin
               check("src_idx_wrapped", 32'(src_idx), 32'd0);
               check("frames_done", 32'(src_frames), 32'(frame_no + 1));
            end
            if (frame_no == 3 && p == 500 && n_init_acc == 1) rst_left = 2;
            if (n_init_acc == 2 && p == 300) done = 1;
         end

         // drive inputs for the coming edge
         reset_drv = (rst_left > 0);
         if (rst_left > 0) rst_left--;
         reset = reset_drv;
         if (mode != M_TIMED) mm_csr_waitrequest = (init_cnt < 6);
         else mm_csr_waitrequest = 1'($urandom_range(0, 1));
         st_valid = 1'b1;
         if (mode == M_TIMED && is_active(p)) begin
            if (frame_no == 1 && p >= 5 * HT + 10 && p < 5 * HT + 20) st_valid = 1'b0;
            else if (frame_no == 2 && $urandom_range(0, 9) == 0) st_valid = 1'b0;
            if (!st_valid) drops++;
         end
         st_endofpacket = (src_idx == ACT);
         st_startofpacket = (src_idx == 0);
         st_data = (frame_no == 0 && src_idx == 0) ? 16'hF81F : 16'($urandom);

         if (reset_drv) begin
            src_idx = 0;
         end else if (st_ready && st_valid) begin
            if (st_endofpacket) begin
               src_idx = 0;
               src_frames++;
            end else begin
               src_idx++;
            end
         end

         if (mode == M_TIMED) begin
            if (st_ready) rdy_cnt++;
            if (!vga_hs_out) hs_lo++;
            if (!vga_vs_out) vs_lo++;
            if (mm_csr_write && !mm_csr_waitrequest) wr_acc++;
         end

         // model: expected outputs for the next cycle
         if (reset_drv) begin
            mode = M_RST;
            e_ready = 0; e_write = 0; e_hs = 1; e_vs = 1; e_rgb = '0;
            drain = 0; init_cnt = 0; have_frame = 0;
         end else begin
            case (mode)
               M_RST: begin
                  mode = M_INIT;
                  e_write = 1;
               end
               M_INIT: begin
                  init_cnt++;
                  if (e_write && !mm_csr_waitrequest) begin
                     mode = M_TIMED;
                     p = 0;
                     n_init_acc++;
                     e_write = 0; e_ready = 1; e_hs = 1; e_vs = 1; e_rgb = '0;
                     drain = 0;
                     rdy_cnt = 0; hs_lo = 0; vs_lo = 0; wr_acc = 0; drops = 0;
                  end else begin
                     e_write = 1;
                  end
               end
               default: begin
                  e_rgb = (is_active(p) && e_ready && st_valid) ? pix(st_data) : 12'h000;
                  e_hs = !in_hsync(p);
                  e_vs = !in_vsync(p);
                  eop_taken = drain && e_ready && st_valid && st_endofpacket;
                  accept = e_write && !mm_csr_waitrequest;
                  pn = (p + 1) % FRAME;
                  if (pn == VA * HT) drain = 1;
                  else if (eop_taken) drain = 0;
                  e_write = eop_taken ? 1'b1 : (e_write && !accept);
                  e_ready = is_active(pn) || drain;
                  p = pn;
               end
            endcase
         end
      end

      check("finished_in_budget", 32'(done), 32'd1);
      check("init_restarts", 32'(n_init_acc), 32'd2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
